switch_scheduler: RTL and testbench

SWITCH_SCHEDULER -- requirements
Module: switch_scheduler

---
 rtl/switch_scheduler_pkg.sv | 21 ++
 rtl/slot_timer.sv | 30 +++
 rtl/switch_scheduler.sv | 115 +++++++++++
 tb/tb_switch_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_scheduler_pkg.sv
// Shared definitions for the photonic switch scheduler: defaults, index width, FSM states.
package switch_scheduler_pkg;

    localparam int NUM_SW_DEF  = 4;
    localparam int LEN_W_DEF   = 8;
    localparam int DEF_LEN_DEF = 25;

    // Slot-index width; a single-channel build still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_w(NUM_SW_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/slot_timer.sv
// Per-slot cycle counter: counts 0..len-1, done on the final cycle of the slot.
module slot_timer
    import switch_scheduler_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    output logic             done
);

    logic [LEN_W-1:0] cnt;

    // A zero-length slot is a one-cycle gap, so it is done immediately.
    assign done = (len == '0) || (cnt == len - LEN_W'(1));

    // Count within the slot; load parks the counter at zero outside sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= done ? '0 : cnt + LEN_W'(1);
    end

endmodule

// File: rtl/switch_scheduler.sv
// Time-slot scheduler for NUM_SW photonic switch channels: FSM, double-buffered
// slot-length banks and one-hot switch decode.
module switch_scheduler
    import switch_scheduler_pkg::*;
#(
    parameter  int NUM_SW  = NUM_SW_DEF,
    parameter  int LEN_W   = LEN_W_DEF,
    parameter  int DEF_LEN = DEF_LEN_DEF,
    localparam int IDX_W   = idx_w(NUM_SW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_wr,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic [NUM_SW-1:0] sw_out,
    output logic [IDX_W-1:0]  slot_idx,
    output logic              frame_pulse,
    output logic              busy
);

    sched_state_e state, state_nxt;
    logic start_pend, stop_pend;
    logic start_eff, stop_eff;
    logic [NUM_SW-1:0][LEN_W-1:0] shadow_len, active_len;
    logic [LEN_W-1:0] cur_len;
    logic done, last_slot, frame_end, bank_load;

    // Requests seen while en is low are held until the next enabled edge.
    assign start_eff = start | start_pend;
    assign stop_eff  = stop | stop_pend;

    assign busy      = (state != ST_IDLE);
    assign cur_len   = active_len[slot_idx];
    assign last_slot = (slot_idx == IDX_W'(NUM_SW - 1));
    assign frame_end = busy && en && done && last_slot;
    assign frame_pulse = frame_end;

    // Active bank reloads at every frame start, including the first one out of IDLE.
    assign bank_load = en && (((state == ST_IDLE) && start_eff) || frame_end);

    // Next-state: start wins in IDLE/DRAIN, stop wins in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_eff) state_nxt = ST_RUN;
            ST_RUN:   if (stop_eff)  state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (start_eff)      state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Sequencing state advances only on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            slot_idx   <= '0;
            start_pend <= 1'b0;
            stop_pend  <= 1'b0;
        end else if (en) begin
            state      <= state_nxt;
            start_pend <= 1'b0;
            stop_pend  <= 1'b0;
            if (state == ST_IDLE)
                slot_idx <= '0;
            else if (done)
                slot_idx <= last_slot ? '0 : slot_idx + IDX_W'(1);
        end else begin
            start_pend <= start_pend | start;
            stop_pend  <= stop_pend | stop;
        end
    end

    // Shadow bank takes writes any time; active bank copies it at frame starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SW; i++) begin
                shadow_len[i] <= LEN_W'(DEF_LEN);
                active_len[i] <= LEN_W'(DEF_LEN);
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (cfg_wr && (int'(cfg_idx) == i))
                    shadow_len[i] <= cfg_len;
                if (bank_load)
                    active_len[i] <= shadow_len[i];
            end
        end
    end

    // One-hot drive for the running slot; gap slots and IDLE drive nothing.
    always_comb begin
        sw_out = '0;
        if (busy && (cur_len != '0))
            sw_out[slot_idx] = 1'b1;
    end

    slot_timer #(
        .LEN_W (LEN_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (en & busy),
        .load  (state == ST_IDLE),
        .len   (cur_len),
        .done  (done)
    );

endmodule

// File: tb/tb_switch_scheduler.sv
// Bench for switch_scheduler: directed frame scenarios plus random traffic,
// every cycle compared against a frame/slot level reference model.
module tb_switch_scheduler;

    localparam int NSW = 4;
    localparam int LW  = 8;
    localparam int DL  = 25;
    localparam int IW  = switch_scheduler_pkg::IDX_W_DEF;

    logic           clk = 1'b0;
    logic           reset, en, start, stop, cfg_wr;
    logic [IW-1:0]  cfg_idx;
    logic [LW-1:0]  cfg_len;
    logic [NSW-1:0] sw_out;
    logic [IW-1:0]  slot_idx;
    logic           frame_pulse, busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = idle, 1 = running, 2 = finishing last frame.
    int m_mode, m_slot, m_tick;
    int m_act[NSW];
    int m_shd[NSW];
    bit m_sp, m_tp;
    bit last_pulse;

    switch_scheduler #(.NUM_SW(NSW), .LEN_W(LW), .DEF_LEN(DL)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_len(cfg_len),
        .sw_out(sw_out), .slot_idx(slot_idx), .frame_pulse(frame_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_slot = 0; m_tick = 0; m_sp = 0; m_tp = 0;
        for (int i = 0; i < NSW; i++) begin
            m_act[i] = DL;
            m_shd[i] = DL;
        end
    endfunction

    // Called at posedge+1: drive inputs, check outputs, advance model to next edge.
    task automatic step(input bit st, input bit sp, input bit e,
                        input bit wr, input int idx, input int len);
        int  eff, e_sw;
        bit  slot_end, e_pulse, s_req, p_req;
        int  shd_old[NSW];
        start = st; stop = sp; en = e; cfg_wr = wr;
        cfg_idx = idx[IW-1:0]; cfg_len = len[LW-1:0];
        #1;
        eff      = (m_act[m_slot] == 0) ? 1 : m_act[m_slot];
        slot_end = (m_tick == eff - 1);
        e_sw     = (m_mode != 0 && m_act[m_slot] != 0) ? (1 << m_slot) : 0;
        e_pulse  = (m_mode != 0) && e && slot_end && (m_slot == NSW - 1);
        chk("sw_out", sw_out, e_sw);
        chk("slot_idx", slot_idx, (m_mode != 0) ? m_slot : 0);
        chk("frame_pulse", frame_pulse, e_pulse);
        chk("busy", busy, m_mode != 0);
        last_pulse = frame_pulse;

        shd_old = m_shd;
        s_req = st | m_sp;
        p_req = sp | m_tp;
        if (!e) begin
            m_sp = s_req;
            m_tp = p_req;
        end else begin
            m_sp = 0; m_tp = 0;
            if (m_mode == 0) begin
                if (s_req) begin
                    m_mode = 1; m_slot = 0; m_tick = 0; m_act = shd_old;
                end
            end else begin
                if (slot_end) begin
                    m_tick = 0;
                    m_slot++;
                    if (m_slot == NSW) begin
                        m_slot = 0;
                        m_act  = shd_old;
                    end
                end else begin
                    m_tick++;
                end
                if (m_mode == 1) begin
                    if (p_req) m_mode = 2;
                end else if (s_req) begin
                    m_mode = 1;
                end else if (e_pulse) begin
                    m_mode = 0;
                end
            end
        end
        if (wr && idx < NSW) m_shd[idx] = len & ((1 << LW) - 1);
        @(posedge clk);
        #1;
    endtask

    // Plain enabled cycle with no requests.
    task automatic idle_step();
        step(0, 0, 1, 0, 0, 0);
    endtask

    // Count enabled cycles until the next frame_pulse (bounded).
    task automatic frame_len(output int n, input int wr_at, input int idx, input int len);
        n = 0;
        for (int k = 1; k <= 600; k++) begin
            step(0, 0, 1, k == wr_at, idx, len);
            n = k;
            if (last_pulse) break;
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        start = 0; stop = 0; cfg_wr = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_sw_out", sw_out, 0);
        chk("rst_slot_idx", slot_idx, 0);
        chk("rst_frame_pulse", frame_pulse, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n, minbusy;
        reset = 1'b1; en = 0; start = 0; stop = 0; cfg_wr = 0; cfg_idx = '0; cfg_len = '0;
        model_reset();
        #12;
        chk("por_sw_out", sw_out, 0);
        chk("por_slot_idx", slot_idx, 0);
        chk("por_frame_pulse", frame_pulse, 0);
        chk("por_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) idle_step();

        // Default lengths: 4 x 25 cycles; shadow[1]=3 written mid-frame.
        step(1, 0, 1, 0, 0, 0);
        frame_len(n, 30, 1, 3);
        chk("frame1_len", n, 100);
        frame_len(n, 0, 0, 0);
        chk("frame2_len", n, 78);
        // Gap slot: shadow[2]=0 lands one frame later.
        frame_len(n, 5, 2, 0);
        chk("frame3_len", n, 78);
        frame_len(n, 0, 0, 0);
        chk("frame4_len", n, 54);

        // Stop in slot 1, drain to IDLE after the frame.
        for (int k = 0; k < 200 && slot_idx != 1; k++) idle_step();
        step(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 300 && busy; k++) idle_step();
        chk("idle_after_drain", busy, 0);

        // Stop then start during DRAIN: busy must stay high throughout.
        step(1, 0, 1, 0, 0, 0);
        repeat (10) idle_step();
        step(0, 1, 1, 0, 0, 0);
        repeat (5) idle_step();
        step(1, 0, 1, 0, 0, 0);
        minbusy = 1;
        for (int k = 0; k < 150; k++) begin
            idle_step();
            if (!busy) minbusy = 0;
        end
        chk("busy_held", minbusy, 1);

        // en low for 10 cycles mid-slot, with requests and a write, then reset mid-frame.
        repeat (7) idle_step();
        for (int k = 0; k < 10; k++) step(k == 3, 0, 0, k == 5, 0, 9);
        repeat (4) idle_step();
        async_reset();

        // Maximum slot length.
        step(0, 0, 1, 1, 0, 255);
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 1, 1, 2, 0);
        step(0, 0, 1, 1, 3, 2);
        step(1, 0, 1, 0, 0, 0);
        frame_len(n, 0, 0, 0);
        chk("maxlen_frame", n, 259);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            int lsel;
            lsel = $urandom_range(0, 4);
            step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, NSW - 1),
                 (lsel == 4) ? $urandom_range(0, 12) : lsel);
            if (k == 2500) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
